// File: rtl/adder2_accum.sv
// Accumulates N_SAMPLES 3-bit adder results {c,s} into an ACC_W-bit sum and
// hands the total plus a sticky overflow flag to a consumer over valid/ready.
module adder2_accum #(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_s,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int                CNT_W    = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_SAMPLES);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   add_full;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             last;
  logic             ovf_new;

  // The sample is the 3-bit value {c,s}; the extra top bit of add_full is the carry-out.
  always_comb begin
    add_full = {1'b0, acc} + {{(ACC_W - 2){1'b0}}, in_c, in_s};
    ovf_new  = ovf | add_full[ACC_W];
    cnt_inc  = cnt + 1'b1;
    accept   = (state == ACCUM) && in_valid && in_ready;
    last     = (cnt_inc == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= add_full[ACC_W-1:0];
            ovf <= ovf_new;
            cnt <= cnt_inc;
            // Closing sample: publish the batch and stop taking input until it is consumed.
            if (last) begin
              state     <= HOLD;
              out_sum   <= add_full[ACC_W-1:0];
              out_ovf   <= ovf_new;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
